fproc_meas_responder: RTL and testbench
=======================================

# fproc_meas_responder

Function-processor responder for the distributed processor's fproc handshake. Each core's `ctrl` raises a one-cycle request with a function id, then stalls until this block returns a one-cycle ready pulse and a data word. Responses are built from per-channel qubit measurement results delivered by the readout path. Each core has its own independent responder FSM, and all of them share one measurement register file.

## Interface
Parameters:
- `N_CORES`, 4, number of processor cores served
- `N_MEAS`, 8, number of measurement channels
- `ID_W`, 8, function id width; `id[ID_W-1]` is the mode bit, `id[ID_W-2:0]` is the channel index
- `DATA_W`, 32, response word width (equals the core ALU width)
- `TIMEOUT`, 1024, maximum wait in cycles for a mode-1 request; 0 disables the timeout

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  one clock; reset is synchronous and active-low
- `fproc_en`  in  N_CORES  per-core request strobe, one cycle
- `fproc_id`  in  N_CORES*ID_W  per-core function id; core c occupies bits `[c*ID_W +: ID_W]`
- `fproc_ready`  out  N_CORES  per-core response strobe, one cycle
- `fproc_data`  out  N_CORES*DATA_W  per-core response word, valid while `fproc_ready[c]` is high
- `meas_valid`  in  N_MEAS  per-channel measurement strobe
- `meas_bit`  in  N_MEAS  per-channel measurement result, sampled when its `meas_valid` bit is high

## Operation
- Measurement register file:
  - `meas_reg[i] <= meas_bit[i]` on every cycle where `meas_valid[i]` is high.
  - All entries reset to 0.
- Response word:
  - `[0]` = measurement bit
  - `[1]` = timeout flag
  - `[2]` = bad-id flag
  - all other bits 0
- Per-core FSM states are IDLE, WAIT_MEAS and RESP.
- IDLE, on `fproc_en[c]`, with `id` captured:
  - Channel index ≥ N_MEAS → RESP with data = 4 (bad-id flag only).
  - Mode 0 → RESP with data[0] = `meas_reg[ch]` as seen that cycle, i.e. the pre-update value.
  - Mode 1 with `meas_valid[ch]` high in the same cycle → RESP with data[0] = `meas_bit[ch]`.
  - Mode 1 otherwise → WAIT_MEAS, wait counter cleared.
- WAIT_MEAS:
  - Counter increments every cycle.
  - On `meas_valid[ch]` → RESP with data[0] = `meas_bit[ch]`.
  - If there is no measurement and `TIMEOUT != 0` and the counter reaches TIMEOUT → RESP with data = {timeout flag = 1, bit = `meas_reg[ch]`}.
  - A measurement in the same cycle as the counter reaching TIMEOUT wins: no timeout flag is set.
- RESP:
  - `fproc_ready[c]` = 1 for exactly one cycle, with `fproc_data` driven from a register.
  - Next state is IDLE.
- `fproc_en[c]` asserted outside IDLE is a protocol violation; it is ignored and causes no state change.
- Cores are fully independent; any number of cores may wait on the same channel, and one `meas_valid` releases all of them in the same cycle.
- Reset, including in the middle of a wait:
  - All FSMs go to IDLE and counters clear.
  - `fproc_ready` = 0 and `fproc_data` = 0.
  - `meas_reg` = 0.
  - No response is issued for requests that were outstanding before reset.

## Timing
- Reset values: `fproc_ready` = 0 and `fproc_data` = 0 on every core.
- Mode 0 and bad-id requests: request at cycle t → `fproc_ready` high at t+1.
- Mode 1 requests: request at t and measurement at cycle m ≥ t → ready at m+1.
- Mode 1 timeout: ready at t+TIMEOUT+1.
- Back-to-back requests: the earliest next request a core can make is at cycle t+2, since the core consumes ready at t+1. The FSM accepts a request on the cycle right after RESP.
- `fproc_data[c]` is held stable from the ready cycle until that core's next response. Verification checks it only while `fproc_ready[c]` is high.
- Counter width is `$clog2(TIMEOUT+1)` with a minimum of 1; it saturates and never wraps.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset behaviour:
  - Stimulus: after reset, core 0 issues mode 0 on channel 3.
  - Required: `fproc_ready[0]` high at t+1 with data = 0.
  - Stimulus: then pulse `meas_valid[3]` with bit = 1, and issue mode 0 again.
  - Required: data = 1.
- Mode 1 wait:
  - Stimulus: core 1 issues id 0x82 at t; `meas_valid[2]` pulses at t+5 with bit = 1.
  - Required: ready at t+6 only, data = 1; no ready at t+1 through t+5.
- Timeout, with TIMEOUT = 16:
  - Stimulus: core 2 issues id 0x81; no measurement arrives; `meas_reg[1]` = 1.
  - Required: ready at t+17 with data = 3.
  - Stimulus: repeat with the measurement arriving exactly at t+16.
  - Required: data = 1, no timeout flag.
- Simultaneous events:
  - Stimulus: cores 0–3 all issue id 0x85; one `meas_valid[5]` pulse with bit = 0 arrives at t+3.
  - Required: all four ready at t+4 with data = 0.
  - Stimulus: a mode-1 request in the same cycle as `meas_valid`.
  - Required: response at t+1 with that bit.
- Bad id and protocol violation:
  - Stimulus: id 0x0A with N_MEAS = 8.
  - Required: ready at t+1 with data = 4.
  - Stimulus: `fproc_en` pulsed during WAIT_MEAS.
  - Required: ignored; only one ready is issued.
- Reset mid-wait:
  - Stimulus: core 0 waits on channel 4; reset is asserted at t+3; the measurement arrives at t+10.
  - Required: no `fproc_ready` at any cycle and `meas_reg[4]` updated.

Source files
------------

// File: rtl/fproc_meas_responder_if.sv
// fproc request/response handshake between the cores' ctrl units and the measurement responder.
// Core c owns bit c of the strobes, bits [c*ID_W +: ID_W] of the id and bits [c*DATA_W +: DATA_W] of the data.
interface fproc_meas_responder_if #(
   parameter int N_CORES = 4,
   parameter int ID_W    = 8,
   parameter int DATA_W  = 32
);
   logic [N_CORES-1:0]        fproc_en;
   logic [N_CORES*ID_W-1:0]   fproc_id;
   logic [N_CORES-1:0]        fproc_ready;
   logic [N_CORES*DATA_W-1:0] fproc_data;

   modport master (
      output fproc_en,
      output fproc_id,
      input  fproc_ready,
      input  fproc_data
   );

   modport slave (
      input  fproc_en,
      input  fproc_id,
      output fproc_ready,
      output fproc_data
   );
endinterface

// File: rtl/fproc_meas_responder.sv
// Answers fproc requests from N_CORES independent ctrl units with qubit measurement results.
// Every core has its own IDLE/WAIT_MEAS/RESP FSM, and all cores read one shared measurement register file.
module fproc_meas_responder #(
   parameter int N_CORES = 4,
   parameter int N_MEAS  = 8,
   parameter int ID_W    = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   fproc_meas_responder_if.slave fproc,
   input  logic [N_MEAS-1:0]     meas_valid,
   input  logic [N_MEAS-1:0]     meas_bit
);
   localparam int CH_W    = ID_W - 1;
   localparam int IDX_W   = (N_MEAS > 1) ? $clog2(N_MEAS) : 1;
   localparam int CNT_RAW = $clog2(TIMEOUT + 1);
   localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
   // The wait starts at 0 one cycle after the request, so TIMEOUT-1 is the last cycle of waiting.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, WAIT_MEAS, RESP} state_t;

   state_t             r_state     [N_CORES];
   state_t             w_state_nxt [N_CORES];
   logic [IDX_W-1:0]   r_ch        [N_CORES];
   logic [CNT_W-1:0]   r_cnt       [N_CORES];
   logic [DATA_W-1:0]  r_data      [N_CORES];
   logic [DATA_W-1:0]  w_word      [N_CORES];
   logic [IDX_W-1:0]   w_idx       [N_CORES];
   logic [N_CORES-1:0] w_go_resp;
   logic [N_CORES-1:0] w_go_wait;
   logic [N_MEAS-1:0]  r_meas_reg;

   // Per-core request decode and response word; word bit 0 = meas, 1 = timeout, 2 = bad id.
   always_comb begin
      for (int c = 0; c < N_CORES; c++) begin
         // NOTE: every output of a combinational block gets a default first so no path infers a latch.
         w_go_resp[c] = 1'b0;
         w_go_wait[c] = 1'b0;
         w_word[c]    = '0;
         w_idx[c]     = fproc.fproc_id[c*ID_W +: IDX_W];
         unique case (r_state[c])
            IDLE: begin
               if (fproc.fproc_en[c]) begin
                  if (int'(fproc.fproc_id[c*ID_W +: CH_W]) >= N_MEAS) begin
                     w_go_resp[c] = 1'b1;
                     w_word[c][2] = 1'b1;
                  end else if (!fproc.fproc_id[c*ID_W + ID_W - 1]) begin
                     w_go_resp[c] = 1'b1;
                     w_word[c][0] = r_meas_reg[w_idx[c]];
                  end else if (meas_valid[w_idx[c]]) begin
                     w_go_resp[c] = 1'b1;
                     w_word[c][0] = meas_bit[w_idx[c]];
                  end else begin
                     w_go_wait[c] = 1'b1;
                  end
               end
            end
            WAIT_MEAS: begin
               if (meas_valid[r_ch[c]]) begin
                  w_go_resp[c] = 1'b1;
                  w_word[c][0] = meas_bit[r_ch[c]];
               end else if ((TIMEOUT != 0) && (r_cnt[c] >= CNT_LAST)) begin
                  w_go_resp[c] = 1'b1;
                  w_word[c][1] = 1'b1;
                  w_word[c][0] = r_meas_reg[r_ch[c]];
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      for (int c = 0; c < N_CORES; c++) begin
         w_state_nxt[c] = r_state[c];
         unique case (r_state[c])
            IDLE: begin
               if (w_go_resp[c])      w_state_nxt[c] = RESP;
               else if (w_go_wait[c]) w_state_nxt[c] = WAIT_MEAS;
            end
            WAIT_MEAS: if (w_go_resp[c]) w_state_nxt[c] = RESP;
            RESP:      w_state_nxt[c] = IDLE;
            default:   w_state_nxt[c] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         // NOTE: the measurement file is only N_MEAS flops and must read 0 after reset, so it is reset like any state.
         r_meas_reg <= '0;
         for (int c = 0; c < N_CORES; c++) begin
            r_state[c] <= IDLE;
            r_ch[c]    <= '0;
            r_cnt[c]   <= '0;
            r_data[c]  <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments, so every reader above sees the pre-edge value of r_meas_reg.
         r_meas_reg <= (r_meas_reg & ~meas_valid) | (meas_bit & meas_valid);
         for (int c = 0; c < N_CORES; c++) begin
            r_state[c] <= w_state_nxt[c];
            if (w_go_wait[c]) begin
               r_ch[c]  <= w_idx[c];
               r_cnt[c] <= '0;
            end else if ((r_state[c] == WAIT_MEAS) && (r_cnt[c] != '1)) begin
               r_cnt[c] <= r_cnt[c] + 1'b1;
            end
            if (w_go_resp[c]) r_data[c] <= w_word[c];
         end
      end
   end

   // Ready decodes straight from the state register and data holds until the next response.
   always_comb begin
      fproc.fproc_ready = '0;
      fproc.fproc_data  = '0;
      for (int c = 0; c < N_CORES; c++) begin
         fproc.fproc_ready[c]                  = (r_state[c] == RESP);
         fproc.fproc_data[c*DATA_W +: DATA_W] = r_data[c];
      end
   end
endmodule

// File: tb/tb_fproc_meas_responder.sv
// Directed bench for fproc_meas_responder with TIMEOUT = 16.
// Inputs change 1 time unit after a rising edge and outputs are sampled at that same point.
module tb_fproc_meas_responder;
   localparam int N_CORES = 4;
   localparam int N_MEAS  = 8;
   localparam int ID_W    = 8;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [N_MEAS-1:0] meas_valid;
   logic [N_MEAS-1:0] meas_bit;
   int                n_assert = 0;
   int                n_fail   = 0;

   fproc_meas_responder_if #(.N_CORES(N_CORES), .ID_W(ID_W), .DATA_W(DATA_W)) bus ();

   fproc_meas_responder #(
      .N_CORES(N_CORES), .N_MEAS(N_MEAS), .ID_W(ID_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .fproc      (bus.slave),
      .meas_valid (meas_valid),
      .meas_bit   (meas_bit)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input int c, input logic [ID_W-1:0] id);
      bus.fproc_en[c]               = 1'b1;
      bus.fproc_id[c*ID_W +: ID_W]  = id;
   endtask

   task automatic meas(input int ch, input logic b);
      meas_valid[ch] = 1'b1;
      meas_bit[ch]   = b;
   endtask

   task automatic idle_inputs();
      bus.fproc_en = '0;
      meas_valid   = '0;
   endtask

   function automatic logic [DATA_W-1:0] data_of(input int c);
      return bus.fproc_data[c*DATA_W +: DATA_W];
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      idle_inputs();
      req(0, 8'h03);
      step(); step(); step();
      n_assert++;
      if (bus.fproc_ready !== 4'b0000) begin
         n_fail++; $display("FAIL rst_ready: got %b expected %b", bus.fproc_ready, 4'b0000);
      end
      n_assert++;
      if (bus.fproc_data !== '0) begin
         n_fail++; $display("FAIL rst_data: got %h expected 0", bus.fproc_data);
      end
      reset = 1'b1;
      idle_inputs();
      step();
      // Mode 0 read of an untouched channel right after reset.
      req(0, 8'h03);
      step(); idle_inputs();
      n_assert++;
      if (bus.fproc_ready !== 4'b0001) begin
         n_fail++; $display("FAIL rst_m0_ready: got %b expected %b", bus.fproc_ready, 4'b0001);
      end
      n_assert++;
      if (data_of(0) !== 32'd0) begin
         n_fail++; $display("FAIL rst_m0_data: got %0h expected %0h", data_of(0), 32'd0);
      end
      meas(3, 1'b1);
      step(); idle_inputs();
      n_assert++;
      if (bus.fproc_ready !== 4'b0000) begin
         n_fail++; $display("FAIL m0_ready_one_cycle: got %b expected %b", bus.fproc_ready, 4'b0000);
      end
      req(0, 8'h03);
      step(); idle_inputs();
      n_assert++;
      if (bus.fproc_ready !== 4'b0001 || data_of(0) !== 32'd1) begin
         n_fail++; $display("FAIL m0_after_meas: got ready %b data %0h expected ready 0001 data 1", bus.fproc_ready, data_of(0));
      end
      // Mode 0 in the same cycle as a new measurement returns the old value.
      step();
      req(0, 8'h03);
      meas(3, 1'b0);
      step(); idle_inputs();
      n_assert++;
      if (bus.fproc_ready !== 4'b0001 || data_of(0) !== 32'd1) begin
         n_fail++; $display("FAIL m0_pre_update: got ready %b data %0h expected ready 0001 data 1", bus.fproc_ready, data_of(0));
      end
      step();
      req(0, 8'h03);
      step(); idle_inputs();
      n_assert++;
      if (bus.fproc_ready !== 4'b0001 || data_of(0) !== 32'd0) begin
         n_fail++; $display("FAIL m0_post_update: got ready %b data %0h expected ready 0001 data 0", bus.fproc_ready, data_of(0));
      end
      step();
   endtask

   task automatic test_mode1_wait();
      req(1, 8'h82);
      for (int k = 1; k <= 5; k++) begin
         step(); idle_inputs();
         n_assert++;
         if (bus.fproc_ready !== 4'b0000) begin
            n_fail++; $display("FAIL m1_early_ready t+%0d: got %b expected %b", k, bus.fproc_ready, 4'b0000);
         end
      end
      meas(2, 1'b1);
      step(); idle_inputs();
      n_assert++;
      if (bus.fproc_ready !== 4'b0010 || data_of(1) !== 32'd1) begin
         n_fail++; $display("FAIL m1_release: got ready %b data %0h expected ready 0010 data 1", bus.fproc_ready, data_of(1));
      end
      step();
      n_assert++;
      if (bus.fproc_ready !== 4'b0000) begin
         n_fail++; $display("FAIL m1_ready_drop: got %b expected %b", bus.fproc_ready, 4'b0000);
      end
   endtask

   task automatic test_timeout();
      meas(1, 1'b1);
      step(); idle_inputs();
      req(2, 8'h81);
      for (int k = 1; k <= TIMEOUT; k++) begin
         step(); idle_inputs();
         n_assert++;
         if (bus.fproc_ready !== 4'b0000) begin
            n_fail++; $display("FAIL to_early_ready t+%0d: got %b expected %b", k, bus.fproc_ready, 4'b0000);
         end
      end
      step();
      n_assert++;
      if (bus.fproc_ready !== 4'b0100 || data_of(2) !== 32'd3) begin
         n_fail++; $display("FAIL to_expire: got ready %b data %0h expected ready 0100 data 3", bus.fproc_ready, data_of(2));
      end
      // Measurement on the very cycle the timeout would fire wins.
      step();
      req(2, 8'h81);
      for (int k = 1; k <= TIMEOUT; k++) begin
         step(); idle_inputs();
      end
      meas(1, 1'b1);
      step(); idle_inputs();
      n_assert++;
      if (bus.fproc_ready !== 4'b0100 || data_of(2) !== 32'd1) begin
         n_fail++; $display("FAIL to_meas_wins: got ready %b data %0h expected ready 0100 data 1", bus.fproc_ready, data_of(2));
      end
      step();
   endtask

   task automatic test_simultaneous();
      meas(5, 1'b1);
      step(); idle_inputs();
      for (int c = 0; c < N_CORES; c++) req(c, 8'h85);
      step(); idle_inputs();
      step(); step();
      n_assert++;
      if (bus.fproc_ready !== 4'b0000) begin
         n_fail++; $display("FAIL sim_early_ready: got %b expected %b", bus.fproc_ready, 4'b0000);
      end
      meas(5, 1'b0);
      step(); idle_inputs();
      n_assert++;
      if (bus.fproc_ready !== 4'b1111) begin
         n_fail++; $display("FAIL sim_all_ready: got %b expected %b", bus.fproc_ready, 4'b1111);
      end
      for (int c = 0; c < N_CORES; c++) begin
         n_assert++;
         if (data_of(c) !== 32'd0) begin
            n_fail++; $display("FAIL sim_data core%0d: got %0h expected 0", c, data_of(c));
         end
      end
      step();
      req(3, 8'h86);
      meas(6, 1'b1);
      step(); idle_inputs();
      n_assert++;
      if (bus.fproc_ready !== 4'b1000 || data_of(3) !== 32'd1) begin
         n_fail++; $display("FAIL m1_same_cycle: got ready %b data %0h expected ready 1000 data 1", bus.fproc_ready, data_of(3));
      end
      step();
   endtask

   task automatic test_bad_id();
      int n_rdy;
      req(1, 8'h0A);
      step(); idle_inputs();
      n_assert++;
      if (bus.fproc_ready !== 4'b0010 || data_of(1) !== 32'd4) begin
         n_fail++; $display("FAIL bad_id_m0: got ready %b data %0h expected ready 0010 data 4", bus.fproc_ready, data_of(1));
      end
      step();
      req(2, 8'h88);
      step(); idle_inputs();
      n_assert++;
      if (bus.fproc_ready !== 4'b0100 || data_of(2) !== 32'd4) begin
         n_fail++; $display("FAIL bad_id_m1: got ready %b data %0h expected ready 0100 data 4", bus.fproc_ready, data_of(2));
      end
      step();
      req(2, 8'h07);
      step(); idle_inputs();
      n_assert++;
      if (bus.fproc_ready !== 4'b0100 || data_of(2) !== 32'd0) begin
         n_fail++; $display("FAIL last_channel: got ready %b data %0h expected ready 0100 data 0", bus.fproc_ready, data_of(2));
      end
      step();
      // Stray request while waiting must be dropped.
      req(0, 8'h84);
      step(); idle_inputs();
      step();
      req(0, 8'h03);
      step(); idle_inputs();
      n_assert++;
      if (bus.fproc_ready !== 4'b0000) begin
         n_fail++; $display("FAIL violation_ready: got %b expected %b", bus.fproc_ready, 4'b0000);
      end
      step();
      meas(4, 1'b1);
      step(); idle_inputs();
      n_assert++;
      if (bus.fproc_ready !== 4'b0001 || data_of(0) !== 32'd1) begin
         n_fail++; $display("FAIL violation_release: got ready %b data %0h expected ready 0001 data 1", bus.fproc_ready, data_of(0));
      end
      n_rdy = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         n_rdy += int'(bus.fproc_ready[0]);
      end
      n_assert++;
      if (n_rdy !== 0) begin
         n_fail++; $display("FAIL violation_extra_ready: got %0d extra readies expected 0", n_rdy);
      end
   endtask

   task automatic test_reset_mid_wait();
      int n0;
      n0 = 0;
      req(0, 8'h84);
      for (int k = 1; k <= 14; k++) begin
         step();
         idle_inputs();
         n0 += int'(bus.fproc_ready[0]);
         reset = (k == 3) ? 1'b0 : 1'b1;
         if (k == 5) req(1, 8'h04);
         if (k == 6) begin
            n_assert++;
            if (bus.fproc_ready[1] !== 1'b1 || data_of(1) !== 32'd0) begin
               n_fail++; $display("FAIL rst_wait_meas_cleared: got ready %b data %0h expected ready 1 data 0", bus.fproc_ready[1], data_of(1));
            end
         end
         if (k == 10) meas(4, 1'b1);
      end
      n_assert++;
      if (n0 !== 0) begin
         n_fail++; $display("FAIL rst_wait_no_ready: got %0d readies on core0 expected 0", n0);
      end
      req(1, 8'h04);
      step(); idle_inputs();
      n_assert++;
      if (bus.fproc_ready !== 4'b0010 || data_of(1) !== 32'd1) begin
         n_fail++; $display("FAIL rst_wait_meas_updated: got ready %b data %0h expected ready 0010 data 1", bus.fproc_ready, data_of(1));
      end
      step();
   endtask

   initial begin
      reset        = 1'b0;
      bus.fproc_en = '0;
      bus.fproc_id = '0;
      meas_valid   = '0;
      meas_bit     = '0;
      test_reset();
      test_mode1_wait();
      test_timeout();
      test_simultaneous();
      test_bad_id();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end
endmodule
